// File: rtl/rv64g_l1_dcache_port_arbiter.sv
// Arbitrates the single rv64g_l1_dcache request port between the scalar LSU and the VLSU,
// with scalar priority and bounded VLSU starvation. Optional perf counters: DCACHE_ARB_PERF_EN.
module rv64g_l1_dcache_port_arbiter #(
  parameter int unsigned MAX_SCALAR_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_req_i,
  input  logic        s_we_i,
  input  logic [7:0]  s_be_i,
  input  logic [63:0] s_addr_i,
  input  logic [63:0] s_wdata_i,
  input  logic        s_amo_i,
  output logic        s_gnt_o,
  output logic        s_rvalid_o,
  output logic [63:0] s_rdata_o,
  input  logic        v_req_i,
  output logic        v_ready_o,
  output logic        v_done_o,
  output logic        c_req_o,
  output logic        c_we_o,
  output logic [7:0]  c_be_o,
  output logic [63:0] c_addr_o,
  output logic [63:0] c_wdata_o,
  output logic        c_amo_o,
  input  logic        c_gnt_i,
  input  logic        c_rvalid_i,
  input  logic [63:0] c_rdata_i,
  output logic        c_vlsu_req_o,
  input  logic        c_vlsu_ready_i,
  input  logic        c_vlsu_done_i,
`ifdef DCACHE_ARB_PERF_EN
  output logic [31:0] perf_s_grants_o,
  output logic [31:0] perf_v_grants_o,
  output logic [31:0] perf_conflict_o,
`endif
  output logic        err_o
);

  localparam int unsigned STREAK_W = (MAX_SCALAR_STREAK < 1) ? 1 : $clog2(MAX_SCALAR_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_SCALAR_STREAK);

  typedef enum logic [1:0] {IDLE, S_WAIT, V_BUSY} state_e;

  state_e              state_q;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                err_q, err_d;
  logic                idle, sel_v, sel_s;

  // Arbitration only in IDLE and never while reset is held, so all outputs read 0 in reset.
  assign idle  = (state_q == IDLE) & ~rst_i;
  assign sel_v = idle & v_req_i & (~s_req_i | (streak_q == STREAK_MAX));
  assign sel_s = idle & s_req_i & ~sel_v;

  assign c_req_o      = sel_s;
  assign c_we_o       = sel_s & s_we_i;
  assign c_be_o       = sel_s ? s_be_i    : 8'h00;
  assign c_addr_o     = sel_s ? s_addr_i  : 64'h0;
  assign c_wdata_o    = sel_s ? s_wdata_i : 64'h0;
  assign c_amo_o      = sel_s & s_amo_i;
  assign s_gnt_o      = sel_s & c_gnt_i;
  assign c_vlsu_req_o = sel_v;
  assign v_ready_o    = sel_v & c_vlsu_ready_i;

  assign s_rvalid_o = c_rvalid_i & (state_q == S_WAIT) & ~rst_i;
  assign s_rdata_o  = s_rvalid_o ? c_rdata_i : 64'h0;
  assign v_done_o   = c_vlsu_done_i & (state_q == V_BUSY) & ~rst_i;
  assign err_o      = err_q;

  // Streak only counts scalar wins that a waiting VLSU request had to watch.
  always_comb begin
    streak_d = streak_q;
    if (!v_req_i || v_ready_o) begin
      streak_d = '0;
    end else if (s_gnt_o && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  // Responses arriving in the wrong state are dropped and flagged.
  assign err_d = err_q | (c_rvalid_i & (state_q != S_WAIT)) | (c_vlsu_done_i & (state_q != V_BUSY));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      streak_q <= streak_d;
      err_q    <= err_d;
      case (state_q)
        IDLE: begin
          if (s_gnt_o) begin
            state_q <= S_WAIT;
          end else if (v_ready_o) begin
            state_q <= V_BUSY;
          end
        end
        S_WAIT:  if (c_rvalid_i)    state_q <= IDLE;
        V_BUSY:  if (c_vlsu_done_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_s_q, perf_s_d, perf_v_q, perf_v_d, perf_c_q, perf_c_d;

  // Saturating event counters.
  always_comb begin
    perf_s_d = perf_s_q;
    perf_v_d = perf_v_q;
    perf_c_d = perf_c_q;
    if (s_gnt_o && (perf_s_q != 32'hFFFF_FFFF)) perf_s_d = perf_s_q + 32'd1;
    if (v_ready_o && (perf_v_q != 32'hFFFF_FFFF)) perf_v_d = perf_v_q + 32'd1;
    if (idle && s_req_i && v_req_i && (perf_c_q != 32'hFFFF_FFFF)) perf_c_d = perf_c_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_s_q <= 32'd0;
      perf_v_q <= 32'd0;
      perf_c_q <= 32'd0;
    end else begin
      perf_s_q <= perf_s_d;
      perf_v_q <= perf_v_d;
      perf_c_q <= perf_c_d;
    end
  end

  assign perf_s_grants_o = perf_s_q;
  assign perf_v_grants_o = perf_v_q;
  assign perf_conflict_o = perf_c_q;
`endif

endmodule

// File: tb/tb_rv64g_l1_dcache_port_arbiter.sv
// Directed self-checking bench for rv64g_l1_dcache_port_arbiter (MAX_SCALAR_STREAK=4).
module tb_rv64g_l1_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        s_req_i, s_we_i, s_amo_i;
  logic [7:0]  s_be_i;
  logic [63:0] s_addr_i, s_wdata_i;
  logic        s_gnt_o, s_rvalid_o;
  logic [63:0] s_rdata_o;
  logic        v_req_i, v_ready_o, v_done_o;
  logic        c_req_o, c_we_o, c_amo_o;
  logic [7:0]  c_be_o;
  logic [63:0] c_addr_o, c_wdata_o;
  logic        c_gnt_i, c_rvalid_i;
  logic [63:0] c_rdata_i;
  logic        c_vlsu_req_o, c_vlsu_ready_i, c_vlsu_done_i;
  logic        err_o;
`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_s_grants_o, perf_v_grants_o, perf_conflict_o;
`endif

  int checks = 0;
  int errors = 0;

  // {s_gnt, s_rvalid, v_ready, v_done, c_req, c_vlsu_req, err}
  logic [6:0] ctl;
  logic       payload_nz;
  assign ctl = {s_gnt_o, s_rvalid_o, v_ready_o, v_done_o, c_req_o, c_vlsu_req_o, err_o};
  assign payload_nz = |{c_we_o, c_be_o, c_addr_o, c_wdata_o, c_amo_o, s_rdata_o};

  rv64g_l1_dcache_port_arbiter #(.MAX_SCALAR_STREAK(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_req_i(s_req_i), .s_we_i(s_we_i), .s_be_i(s_be_i), .s_addr_i(s_addr_i),
    .s_wdata_i(s_wdata_i), .s_amo_i(s_amo_i),
    .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
    .v_req_i(v_req_i), .v_ready_o(v_ready_o), .v_done_o(v_done_o),
    .c_req_o(c_req_o), .c_we_o(c_we_o), .c_be_o(c_be_o), .c_addr_o(c_addr_o),
    .c_wdata_o(c_wdata_o), .c_amo_o(c_amo_o),
    .c_gnt_i(c_gnt_i), .c_rvalid_i(c_rvalid_i), .c_rdata_i(c_rdata_i),
    .c_vlsu_req_o(c_vlsu_req_o), .c_vlsu_ready_i(c_vlsu_ready_i), .c_vlsu_done_i(c_vlsu_done_i),
`ifdef DCACHE_ARB_PERF_EN
    .perf_s_grants_o(perf_s_grants_o), .perf_v_grants_o(perf_v_grants_o),
    .perf_conflict_o(perf_conflict_o),
`endif
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    s_req_i = 0; s_we_i = 0; s_amo_i = 0; s_be_i = 8'h00;
    s_addr_i = 64'h0; s_wdata_i = 64'h0;
    v_req_i = 0; c_gnt_i = 0; c_rvalid_i = 0; c_rdata_i = 64'h0;
    c_vlsu_ready_i = 0; c_vlsu_done_i = 0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_i = 1;
    cyc();
    rst_i = 0;
  endtask

  task automatic test_reset();
    // Busy inputs while reset is held: every output must still read 0.
    rst_i = 1;
    clr_in();
    s_req_i = 1; s_we_i = 1; s_amo_i = 1; s_be_i = 8'hFF; s_addr_i = 64'h55;
    s_wdata_i = 64'h77; v_req_i = 1; c_gnt_i = 1; c_vlsu_ready_i = 1;
    c_rvalid_i = 1; c_rdata_i = 64'h99; c_vlsu_done_i = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL rst_ctl got %b exp 0000000", ctl); end
    checks++;
    if (payload_nz !== 1'b0) begin errors++; $display("FAIL rst_payload got %b exp 0", payload_nz); end
    cyc();
    rst_i = 0;
    clr_in();
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0 || payload_nz !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle got ctl=%b pl=%b exp 0/0", ctl, payload_nz);
    end
`ifdef DCACHE_ARB_PERF_EN
    checks++;
    if ({perf_s_grants_o, perf_v_grants_o, perf_conflict_o} !== 96'h0) begin
      errors++; $display("FAIL rst_perf got %0d/%0d/%0d exp 0/0/0", perf_s_grants_o, perf_v_grants_o, perf_conflict_o);
    end
`endif
    cyc();
  endtask

  task automatic test_scalar_load();
    clr_in();
    s_req_i = 1; s_be_i = 8'hFF; s_addr_i = 64'h1000; c_gnt_i = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1000100) begin errors++; $display("FAIL ld_grant got %b exp 1000100", ctl); end
    checks++;
    if ({c_addr_o, c_be_o, c_we_o} !== {64'h1000, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL ld_payload got %h/%h/%b exp 1000/ff/0", c_addr_o, c_be_o, c_we_o);
    end
    cyc();
    clr_in();
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0 || payload_nz !== 1'b0) begin
      errors++; $display("FAIL ld_wait got ctl=%b pl=%b exp 0/0", ctl, payload_nz);
    end
    cyc();
    // Response arrives; a pending scalar request must not be granted this cycle.
    c_rvalid_i = 1; c_rdata_i = 64'hDEAD; s_req_i = 1; s_addr_i = 64'h2000; c_gnt_i = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0100000) begin errors++; $display("FAIL ld_rvalid_ctl got %b exp 0100000", ctl); end
    checks++;
    if (s_rdata_o !== 64'hDEAD) begin errors++; $display("FAIL ld_rdata got %h exp dead", s_rdata_o); end
    cyc();
    c_rvalid_i = 0; c_rdata_i = 64'h0;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1000100 || c_addr_o !== 64'h2000) begin
      errors++; $display("FAIL ld_back_idle got ctl=%b addr=%h exp 1000100/2000", ctl, c_addr_o);
    end
    cyc();
    clr_in();
    c_rvalid_i = 1; c_rdata_i = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    checks++;
    if (s_rvalid_o !== 1'b1 || s_rdata_o !== 64'h1234_5678_9ABC_DEF0) begin
      errors++; $display("FAIL ld2_resp got %b/%h exp 1/123456789abcdef0", s_rvalid_o, s_rdata_o);
    end
    cyc();
    clr_in();
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_s;
    exp_s = 10'b0111101111; // bit g set => grant g goes to scalar (g=0 first)
    do_reset();
    for (int g = 0; g < 10; g++) begin
      clr_in();
      s_req_i = 1; v_req_i = 1; c_gnt_i = 1; c_vlsu_ready_i = 1; s_addr_i = 64'(g);
      @(negedge clk);
      checks++;
      if ({s_gnt_o, v_ready_o} !== {exp_s[g], ~exp_s[g]}) begin
        errors++; $display("FAIL b2b_grant%0d got s=%b v=%b exp s=%b", g, s_gnt_o, v_ready_o, exp_s[g]);
      end
      cyc();
      c_rvalid_i = exp_s[g]; c_vlsu_done_i = ~exp_s[g];
      @(negedge clk);
      checks++;
      if (ctl[6:3] !== {1'b0, exp_s[g], 1'b0, ~exp_s[g]}) begin
        errors++; $display("FAIL b2b_resp%0d got %b exp %b", g, ctl[6:3], {1'b0, exp_s[g], 1'b0, ~exp_s[g]});
      end
      cyc();
    end
    clr_in();
`ifdef DCACHE_ARB_PERF_EN
    checks++;
    if ({perf_s_grants_o, perf_v_grants_o, perf_conflict_o} !== {32'd8, 32'd2, 32'd10}) begin
      errors++; $display("FAIL perf_counts got %0d/%0d/%0d exp 8/2/10", perf_s_grants_o, perf_v_grants_o, perf_conflict_o);
    end
`endif
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err_o); end
  endtask

  task automatic test_vlsu_busy();
    do_reset();
    v_req_i = 1; c_vlsu_ready_i = 1; c_gnt_i = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0010010) begin errors++; $display("FAIL v_accept got %b exp 0010010", ctl); end
    cyc();
    for (int i = 1; i <= 7; i++) begin
      clr_in();
      s_req_i = 1; c_gnt_i = 1; c_vlsu_done_i = (i == 7);
      @(negedge clk);
      checks++;
      if (ctl !== {3'b000, (i == 7), 3'b000}) begin
        errors++; $display("FAIL v_busy%0d got %b exp %b", i, ctl, {3'b000, (i == 7), 3'b000});
      end
      cyc();
    end
    c_vlsu_done_i = 0;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1000100) begin errors++; $display("FAIL v_after_done got %b exp 1000100", ctl); end
    cyc();
    clr_in();
    c_rvalid_i = 1;
    cyc();
    clr_in();
  endtask

  task automatic test_stray_resp();
    do_reset();
    c_rvalid_i = 1; c_rdata_i = 64'hBEEF;
    @(negedge clk);
    checks++;
    if (s_rvalid_o !== 1'b0 || s_rdata_o !== 64'h0) begin
      errors++; $display("FAIL stray_fwd got %b/%h exp 0/0", s_rvalid_o, s_rdata_o);
    end
    cyc();
    clr_in();
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL stray_err_sticky got %b exp 1", err_o); end
    do_reset();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", err_o); end
    cyc();
    c_vlsu_done_i = 1;
    @(negedge clk);
    checks++;
    if (v_done_o !== 1'b0) begin errors++; $display("FAIL stray_done_fwd got %b exp 0", v_done_o); end
    cyc();
    clr_in();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL stray_done_err got %b exp 1", err_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_req_i = 1; c_gnt_i = 1; s_addr_i = 64'h3000;
    @(negedge clk);
    checks++;
    if (s_gnt_o !== 1'b1) begin errors++; $display("FAIL mid_grant got %b exp 1", s_gnt_o); end
    cyc();
    rst_i = 1; s_req_i = 1; c_gnt_i = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0 || payload_nz !== 1'b0) begin
      errors++; $display("FAIL mid_in_rst got ctl=%b pl=%b exp 0/0", ctl, payload_nz);
    end
    cyc();
    rst_i = 0; clr_in();
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0 || payload_nz !== 1'b0) begin
      errors++; $display("FAIL mid_after_rst got ctl=%b pl=%b exp 0/0", ctl, payload_nz);
    end
    cyc();
    c_rvalid_i = 1; c_rdata_i = 64'hCAFE;
    @(negedge clk);
    checks++;
    if (s_rvalid_o !== 1'b0) begin errors++; $display("FAIL mid_late_rvalid got %b exp 0", s_rvalid_o); end
    cyc();
    clr_in();
    s_req_i = 1; c_gnt_i = 1;
    @(negedge clk);
    checks++;
    if ({err_o, s_gnt_o} !== 2'b11) begin
      errors++; $display("FAIL mid_err_idle got err=%b gnt=%b exp 1/1", err_o, s_gnt_o);
    end
    cyc();
    clr_in();
    c_rvalid_i = 1;
    cyc();
    clr_in();
  endtask

  initial begin
    test_reset();
    test_scalar_load();
    test_back_to_back();
    test_vlsu_busy();
    test_stray_resp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
